// File: rtl/gpio_bus_arbiter.sv
// Round-robin two-master arbiter for the GPIO peripheral register bus.
// Define GPIO_ARB_LOCK_EN to let the owner hold the bus for back-to-back accesses.
module gpio_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  input  logic              m0_lock_i,
  output logic              m0_gnt_o,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic              m1_lock_i,
  output logic              m1_gnt_o,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              owner;
  logic              last;
  logic              sel;
  logic              hold;
  logic              in_access;
  logic [DATA_W-1:0] rdata_q;

  // On a tie the master that did not go last wins; otherwise the lone requester.
  assign sel = (m0_req_i && m1_req_i) ? ~last : m1_req_i;

`ifdef GPIO_ARB_LOCK_EN
  assign hold = owner ? (m1_lock_i & m1_req_i) : (m0_lock_i & m0_req_i);
`else
  logic unused_lock;
  assign unused_lock = m0_lock_i | m1_lock_i;
  assign hold        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      rdata_q  <= '0;
      m0_gnt_o <= 1'b0;
      m1_gnt_o <= 1'b0;
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
    end else begin
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            owner    <= sel;
            m0_gnt_o <= ~sel;
            m1_gnt_o <= sel;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q  <= s_data_i;
          last     <= owner;
          m0_ack_o <= ~owner;
          m1_ack_o <= owner;
          state    <= RESP;
        end
        RESP: begin
          if (hold) begin
            state <= ACCESS;
          end else begin
            m0_gnt_o <= 1'b0;
            m1_gnt_o <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          m0_gnt_o <= 1'b0;
          m1_gnt_o <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // The slave bus is gated by state so reset kills a write enable immediately.
  assign in_access = (state == ACCESS);
  assign s_we_o    = in_access & (owner ? m1_we_i : m0_we_i);
  assign s_addr_o  = in_access ? (owner ? m1_addr_i : m0_addr_i) : '0;
  assign s_data_o  = in_access ? (owner ? m1_data_i : m0_data_i) : '0;

  assign m0_data_o = m0_ack_o ? rdata_q : '0;
  assign m1_data_o = m1_ack_o ? rdata_q : '0;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Scoreboard bench for gpio_bus_arbiter: drivers queue expectations, a negedge monitor checks them.
// The slave is a combinational ROM returning addr + 0xA.
module tb_gpio_bus_arbiter;

`ifdef GPIO_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
  logic        m0_gnt_o, m0_ack_o, m1_gnt_o, m1_ack_o, s_we_o;
  logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o, s_data_i;

  int vectors = 0;
  int errors  = 0;
  int cycle   = 0;
  int we_cnt  = 0;
  bit m1_gnt_seen = 1'b0;

  bit          oq[$];
  logic [31:0] dq0[$];
  logic [31:0] dq1[$];
  logic [63:0] wq[$];
  int          ack_cyc[$];

  gpio_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_data),
    .m0_lock_i(m0_lock), .m0_gnt_o(m0_gnt_o), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_data),
    .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt_o), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i)
  );

  always #5 clk = ~clk;

  assign s_data_i = s_addr_o + 32'h0000_000A;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every write strobe and every ack is matched against the queues.
  always @(negedge clk) begin
    bit exp_id;
    cycle++;
    if (m1_gnt_o) m1_gnt_seen = 1'b1;
    if (s_we_o) begin
      we_cnt++;
      if (wq.size() == 0) begin
        vectors++;
        errors++;
        $display("[TB] FAIL unexpected write: got addr %0h data %0h expected none", s_addr_o, s_data_o);
      end else begin
        check_output("slave write addr/data", {s_addr_o, s_data_o}, wq.pop_front());
      end
    end
    if (m0_ack_o || m1_ack_o) begin
      ack_cyc.push_back(cycle);
      if (oq.size() == 0) begin
        vectors++;
        errors++;
        $display("[TB] FAIL unexpected ack: got m0=%0b m1=%0b expected none", m0_ack_o, m1_ack_o);
      end else begin
        exp_id = oq.pop_front();
        check_output("ack pair", {m1_ack_o, m0_ack_o}, exp_id ? 64'd2 : 64'd1);
        if (m1_ack_o && !m0_ack_o && dq1.size() > 0) begin
          check_output("m1 read data", m1_data_o, dq1.pop_front());
          check_output("m0 data while m1 acks", m0_data_o, 0);
        end else if (m0_ack_o && !m1_ack_o && dq0.size() > 0) begin
          check_output("m0 read data", m0_data_o, dq0.pop_front());
          check_output("m1 data while m0 acks", m1_data_o, 0);
        end
      end
    end
  end

  // One complete master transaction: raise request, wait for ack, drop after it.
  task automatic apply_stimulus(input bit m, input bit we, input logic [31:0] addr,
                                input logic [31:0] data, input bit lock);
    int t;
    if (!m) begin
      m0_we = we; m0_addr = addr; m0_data = data; m0_lock = lock; m0_req = 1'b1;
      dq0.push_back(addr + 32'h0000_000A);
    end else begin
      m1_we = we; m1_addr = addr; m1_data = data; m1_lock = lock; m1_req = 1'b1;
      dq1.push_back(addr + 32'h0000_000A);
    end
    if (we) wq.push_back({addr, data});
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(m ? m1_ack_o : m0_ack_o) && t < 40);
    check_output(m ? "m1 ack arrives" : "m0 ack arrives", m ? m1_ack_o : m0_ack_o, 1);
    @(posedge clk);
    #1;
    if (!m) begin m0_req = 1'b0; m0_lock = 1'b0; end
    else begin m1_req = 1'b0; m1_lock = 1'b0; end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_data = '0; m0_lock = 1'b0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_data = '0; m1_lock = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start, we0, t;
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    check_output("reset gnt/ack/we", {m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o, s_we_o}, 0);
    check_output("reset s_addr", s_addr_o, 0);
    check_output("reset s_data", s_data_o, 0);
    check_output("reset m0_data", m0_data_o, 0);
    check_output("reset m1_data", m1_data_o, 0);
    do_reset();

    // m0 write: ack lands three monitor ticks after issue, one write strobe, m1 untouched
    ack_cyc.delete(); we0 = we_cnt; m1_gnt_seen = 1'b0; start = cycle;
    oq.push_back(1'b0);
    apply_stimulus(1'b0, 1'b1, 32'h4, 32'hA5A5_0001, 1'b0);
    check_output("s1 write strobes", we_cnt - we0, 1);
    check_output("s1 m1 grant seen", m1_gnt_seen, 0);
    check_output("s1 ack count", ack_cyc.size(), 1);
    if (ack_cyc.size() == 1) check_output("s1 ack latency", ack_cyc[0] - start, 3);

    // m1 read of addr 0 returns 0xA with no write strobe
    @(posedge clk); #1;
    we0 = we_cnt;
    oq.push_back(1'b1);
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    check_output("s2 write strobes", we_cnt - we0, 0);

    // both masters requesting continuously alternate with 3-cycle ack spacing
    do_reset();
    ack_cyc.delete();
    oq.push_back(1'b0); oq.push_back(1'b1); oq.push_back(1'b0); oq.push_back(1'b1);
    fork
      begin
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h14, 32'h0, 1'b0);
      end
      begin
        apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
      end
    join
    check_output("s3 ack count", ack_cyc.size(), 4);
    if (ack_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check_output("s3 ack spacing", ack_cyc[i] - ack_cyc[i-1], 3);

    // reset pulsed during ACCESS of an m0 write
    do_reset();
    ack_cyc.delete();
    m0_we = 1'b1; m0_addr = 32'h8; m0_data = 32'h5A5A_0008; m0_req = 1'b1;
    wq.push_back({32'h8, 32'h5A5A_0008});
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m0_gnt_o && t < 10);
    check_output("s4 grant before reset", m0_gnt_o, 1);
    #1 rst = 1'b0;
    #1;
    check_output("s4 s_we after reset", s_we_o, 0);
    check_output("s4 gnt after reset", m0_gnt_o, 0);
    m0_req = 1'b0; m0_we = 1'b0;
    repeat (3) @(negedge clk);
    check_output("s4 acks during reset", ack_cyc.size(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    oq.push_back(1'b0); oq.push_back(1'b1);
    fork
      apply_stimulus(1'b0, 1'b0, 32'h30, 32'h0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 32'h34, 32'h0, 1'b0);
    join

    // m0 locked chain of four writes with m1 waiting
    do_reset();
    ack_cyc.delete();
    if (LOCK) begin
      oq.push_back(1'b0); oq.push_back(1'b0); oq.push_back(1'b0); oq.push_back(1'b0); oq.push_back(1'b1);
    end else begin
      oq.push_back(1'b0); oq.push_back(1'b1); oq.push_back(1'b0); oq.push_back(1'b0); oq.push_back(1'b0);
    end
    fork
      begin
        apply_stimulus(1'b0, 1'b1, 32'h40, 32'hD000_0000, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h44, 32'hD000_0001, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h48, 32'hD000_0002, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h4C, 32'hD000_0003, 1'b0);
      end
      apply_stimulus(1'b1, 1'b0, 32'h50, 32'h0, 1'b0);
    join
    check_output("s5 ack count", ack_cyc.size(), 5);
    if (ack_cyc.size() == 5)
      for (int i = 1; i < 5; i++)
        check_output("s5 ack spacing", ack_cyc[i] - ack_cyc[i-1], (LOCK && i < 4) ? 2 : 3);

    repeat (5) @(negedge clk);
    check_output("order queue drained", oq.size(), 0);
    check_output("m0 data queue drained", dq0.size(), 0);
    check_output("m1 data queue drained", dq1.size(), 0);
    check_output("write queue drained", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by %0t expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
